// File: rtl/execute_stage.sv
// Execute stage of the Y86-64 pipeline.
// Selects ALU operands from the decoded fields, computes valE, holds the
// ZF/SF/OF condition-code register, evaluates jXX/cmovXX conditions and
// latches the execute/memory pipeline register (with bubble insertion).
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   E_*                    decode/execute register fields
//   m_stat, W_stat         status in the memory and writeback stages
//   M_bubble               load a bubble into the M register this cycle
//   e_valE, e_dstE, e_cnd  combinational results used for forwarding
//   M_*                    registered execute/memory pipeline register
//   CC_ZF, CC_SF, CC_OF    condition-code register
module execute_stage #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valC,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [2:0]   m_stat,
    input  logic [2:0]   W_stat,
    input  logic         M_bubble,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_dstE,
    output logic         e_cnd,
    output logic [2:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM,
    output logic         CC_ZF,
    output logic         CC_SF,
    output logic         CC_OF
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h1;
    localparam logic [3:0] F_AND = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [W-1:0] POS8 = W'(8);
    localparam logic [W-1:0] NEG8 = ~W'(7);

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_fun;
    logic [W-1:0] alu_res;
    logic         alu_of;
    logic         set_cc;
    logic         m_exc;
    logic         w_exc;
    logic         lt;

    logic         cc_zf_q, cc_zf_d;
    logic         cc_sf_q, cc_sf_d;
    logic         cc_of_q, cc_of_d;

    logic [2:0]   m_stat_q,  m_stat_d;
    logic [3:0]   m_icode_q, m_icode_d;
    logic         m_cnd_q,   m_cnd_d;
    logic [W-1:0] m_vale_q,  m_vale_d;
    logic [W-1:0] m_vala_q,  m_vala_d;
    logic [3:0]   m_dste_q,  m_dste_d;
    logic [3:0]   m_dstm_q,  m_dstm_d;

    // Operand selection
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:            alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
            I_CALL, I_PUSHQ:            alu_a = NEG8;
            I_RET, I_POPQ:              alu_a = POS8;
            default:                    alu_a = '0;
        endcase
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_RET, I_PUSHQ, I_POPQ:     alu_b = E_valB;
            default:                    alu_b = '0;
        endcase
    end

    // ALU and overflow detection; unknown OPq functions yield 0 with no flags
    always_comb begin
        alu_fun = (E_icode == I_OPQ) ? E_ifun : F_ADD;
        alu_res = '0;
        alu_of  = 1'b0;
        case (alu_fun)
            F_ADD: begin
                alu_res = alu_b + alu_a;
                alu_of  = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
            end
            F_SUB: begin
                alu_res = alu_b + ~alu_a + W'(1);
                alu_of  = (alu_a[W-1] != alu_b[W-1]) && (alu_res[W-1] != alu_b[W-1]);
            end
            F_AND:   alu_res = alu_b & alu_a;
            F_XOR:   alu_res = alu_b ^ alu_a;
            default: alu_res = '0;
        endcase
    end

    // Flags are frozen while an exception sits in memory or writeback
    always_comb begin
        m_exc  = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
        w_exc  = (W_stat == S_HLT) || (W_stat == S_ADR) || (W_stat == S_INS);
        set_cc = (E_icode == I_OPQ) && (E_ifun <= F_XOR) && !m_exc && !w_exc;
    end

    // Branch / conditional-move evaluation against the current CC
    always_comb begin
        lt    = cc_sf_q ^ cc_of_q;
        e_cnd = 1'b0;
        case (E_ifun)
            4'h0:    e_cnd = 1'b1;
            4'h1:    e_cnd = lt | cc_zf_q;
            4'h2:    e_cnd = lt;
            4'h3:    e_cnd = cc_zf_q;
            4'h4:    e_cnd = ~cc_zf_q;
            4'h5:    e_cnd = ~lt;
            4'h6:    e_cnd = ~lt & ~cc_zf_q;
            default: e_cnd = 1'b0;
        endcase
    end

    // Forwarding outputs; a failed cmov suppresses the register write
    always_comb begin
        e_valE = alu_res;
        e_dstE = ((E_icode == I_RRMOVQ) && !e_cnd) ? R_NONE : E_dstE;
    end

    // Next-state for CC and the M register
    always_comb begin
        cc_zf_d = cc_zf_q;
        cc_sf_d = cc_sf_q;
        cc_of_d = cc_of_q;
        if (set_cc) begin
            cc_zf_d = (alu_res == '0);
            cc_sf_d = alu_res[W-1];
            cc_of_d = alu_of;
        end

        m_stat_d  = S_AOK;
        m_icode_d = I_NOP;
        m_cnd_d   = 1'b0;
        m_vale_d  = '0;
        m_vala_d  = '0;
        m_dste_d  = R_NONE;
        m_dstm_d  = R_NONE;
        if (!M_bubble) begin
            m_stat_d  = E_stat;
            m_icode_d = E_icode;
            m_cnd_d   = e_cnd;
            m_vale_d  = e_valE;
            m_vala_d  = E_valA;
            m_dste_d  = e_dstE;
            m_dstm_d  = E_dstM;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_zf_q   <= 1'b1;
            cc_sf_q   <= 1'b0;
            cc_of_q   <= 1'b0;
            m_stat_q  <= S_AOK;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= R_NONE;
            m_dstm_q  <= R_NONE;
        end else begin
            cc_zf_q   <= cc_zf_d;
            cc_sf_q   <= cc_sf_d;
            cc_of_q   <= cc_of_d;
            m_stat_q  <= m_stat_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_vale_q  <= m_vale_d;
            m_vala_q  <= m_vala_d;
            m_dste_q  <= m_dste_d;
            m_dstm_q  <= m_dstm_d;
        end
    end

    assign CC_ZF   = cc_zf_q;
    assign CC_SF   = cc_sf_q;
    assign CC_OF   = cc_of_q;
    assign M_stat  = m_stat_q;
    assign M_icode = m_icode_q;
    assign M_cnd   = m_cnd_q;
    assign M_valE  = m_vale_q;
    assign M_valA  = m_vala_q;
    assign M_dstE  = m_dste_q;
    assign M_dstM  = m_dstm_q;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the Y86-64 pipeline, between the decode/execute register and the memory stage.
- Selects ALU operands from decoded fields and computes valE using the team's 64-bit add, subtract, and and xor logic.
- Holds the condition-code register (ZF/SF/OF) and evaluates jXX/cmovXX conditions.
- Latches the execute/memory pipeline register, with bubble control from the hazard unit.

Parameters:
- W, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- E_stat  in  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- E_icode  in  4  instruction code: 0 halt, 1 nop, 2 rrmovq/cmov, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
- E_ifun  in  4  function code.
- E_valC  in  64  constant word.
- E_valA  in  64  operand A.
- E_valB  in  64  operand B.
- E_dstE  in  4  destination register for valE; 0xF means none.
- E_dstM  in  4  destination register for the memory result.
- m_stat  in  3  status currently in the memory stage.
- W_stat  in  3  status currently in the writeback stage.
- M_bubble  in  1  load a bubble into the M register this cycle.
- e_valE  out  64  combinational ALU result, used for forwarding.
- e_dstE  out  4  combinational effective dstE, used for forwarding.
- e_cnd  out  1  combinational condition result.
- M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM  out  3/4/1/64/64/4/4  registered execute/memory pipeline register.
- CC_ZF, CC_SF, CC_OF  out  1 each  condition-code register.

Behaviour:
- ALU operand A (aluA):
  - valA for icode 2 and 6.
  - valC for icode 3, 4, 5.
  - −8 (0xFFFF_FFFF_FFFF_FFF8) for icode 8 and A.
  - +8 for icode 9 and B.
  - 0 otherwise.
- ALU operand B (aluB):
  - valB for icode 4, 5, 6, 8, 9, A, B.
  - 0 for icode 2 and 3, and otherwise.
- ALU function: ifun when icode = 6, otherwise add.
  - ifun 0: aluB + aluA.
  - ifun 1: aluB − aluA (two's complement: aluB + ~aluA + 1).
  - ifun 2: aluB & aluA.
  - ifun 3: aluB ^ aluA.
  - ifun > 3 with icode 6: result 0, CC not written.
- Arithmetic is modulo 2^64; carry-out is discarded.
- Overflow (OF):
  - add: sign(A) = sign(B) and sign(result) ≠ sign(A).
  - sub: sign(A) ≠ sign(B) and sign(result) ≠ sign(B).
  - and/xor: OF = 0.
- Flag values: ZF = (result == 0), SF = result[63].
- CC write (set_cc) requires all of:
  - icode = 6 and ifun ≤ 3;
  - m_stat ∉ {2, 3, 4};
  - W_stat ∉ {2, 3, 4}.
- When set_cc is true, CC loads the new flags at the rising edge; otherwise CC holds.
- Condition e_cnd uses the current (pre-update) CC:
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF) | ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): ~ZF.
  - ifun 5 (ge): ~(SF^OF).
  - ifun 6 (g): ~(SF^OF) & ~ZF.
  - ifun > 6: 0.
- e_dstE = 0xF when icode = 2 and e_cnd = 0; otherwise E_dstE.
- M register load:
  - With no bubble, M_* ← {E_stat, E_icode, e_cnd, e_valE, E_valA, e_dstE, E_dstM} at the rising edge.
  - The latency from E inputs to M outputs is one cycle.
- Bubble (M_bubble = 1): M register loads stat=1, icode=1, cnd=0, valE=0, valA=0, dstE=0xF, dstM=0xF. CC behaviour is still governed only by set_cc.
- Reset:
  - rst has priority over M_bubble and set_cc.
  - M register takes the bubble values.
  - CC_ZF=1, CC_SF=0, CC_OF=0.
  - Reset asserted mid-stream discards the in-flight instruction; the first post-reset edge with rst=0 loads normally.
- Simultaneous events: set_cc and M_bubble in the same cycle means CC updates and M takes the bubble.
- No stall input: the M register loads every non-reset cycle.

Test Plan:
- Reset: hold rst for 2 cycles with arbitrary E_* inputs → M_icode=1, M_dstE=0xF, M_stat=1, CC = ZF1/SF0/OF0.
- Sub overflow: icode 6, ifun 1, valA = 1, valB = 0x8000_0000_0000_0000 → e_valE = 0x7FFF_FFFF_FFFF_FFFF; after the edge CC = ZF0, SF0, OF1.
- Add zero: icode 6, ifun 0, valA = 0xFFFF_FFFF_FFFF_FFFF, valB = 1 → e_valE = 0, ZF=1, OF=0. Repeat with m_stat=3 → CC unchanged.
- Stack ops:
  - pushq with valB = 0x100 → e_valE = 0xF8.
  - popq with valB = 0x100 → e_valE = 0x108.
  - mrmovq with valC = 0x20, valB = 0x40 → e_valE = 0x60, with M_dstM passed through.
- Conditional move: CC = ZF1, then cmovne (icode 2, ifun 4, dstE = 3) → e_cnd=0, e_dstE=0xF. With ifun 3 (cmove) → e_cnd=1, e_dstE=3.
- Bubble: M_bubble=1 together with a valid OPq → M_icode=1, M_dstE=0xF, and CC updated from the OPq result.
